// File: rtl/sqrt_dispatch.sv
// Operand FIFO plus a one-at-a-time launcher for the sqrt32 core.
// Each result is returned on a valid/ready stream together with the operand that produced it.
module sqrt_dispatch #(
    parameter int DEPTH        = 4,
    parameter int START_CYCLES = 2,
    parameter int TIMEOUT      = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    // Both streams: a beat transfers on the rising edge where valid and ready are both 1.
    // valid never waits on ready, and a held beat keeps its data stable until it transfers.
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_data,
    output logic                     sq_start,
    output logic [31:0]              sq_x,
    input  logic                     sq_rdy,
    input  logic [15:0]              sq_y,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              out_y,
    output logic [31:0]              out_x,
    output logic                     out_err,
    output logic [$clog2(DEPTH):0]   level,
    output logic [1:0]               dbg_state
);

    localparam int AW   = $clog2(DEPTH);
    localparam int MAXC = (TIMEOUT > START_CYCLES) ? TIMEOUT : START_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] START_LAST = CW'(START_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST    = CW'(TIMEOUT - 1);
    localparam logic [AW:0]   FULL_LEVEL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     level_q, level_d;
    logic [31:0]     mem_q [DEPTH];
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            sq_start_q, sq_start_d;
    logic [31:0]     sq_x_q, sq_x_d;
    logic            out_valid_q, out_valid_d;
    logic [15:0]     out_y_q, out_y_d;
    logic [31:0]     out_x_q, out_x_d;
    logic            out_err_q, out_err_d;

    logic push;
    logic launch;
    logic load_done;
    logic rdy_hit;
    logic timed_out;

    // in_ready is gated by reset so nothing is accepted while the block is held in reset.
    assign in_ready  = reset && (level_q != FULL_LEVEL);
    assign push      = in_valid && in_ready;
    assign launch    = (state_q == S_IDLE) && (level_q != '0) && !out_valid_q;
    assign load_done = (state_q == S_LOAD) && (cnt_q == START_LAST);
    // The first WAIT cycle may still see rdy left over from the previous operation.
    assign rdy_hit   = (state_q == S_WAIT) && (cnt_q != '0) && sq_rdy;
    assign timed_out = (state_q == S_WAIT) && !rdy_hit && (cnt_q == TO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            cnt_q       <= '0;
            sq_start_q  <= 1'b0;
            sq_x_q      <= '0;
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
            out_x_q     <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            cnt_q       <= cnt_d;
            sq_start_q  <= sq_start_d;
            sq_x_q      <= sq_x_d;
            out_valid_q <= out_valid_d;
            out_y_q     <= out_y_d;
            out_x_q     <= out_x_d;
            out_err_q   <= out_err_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (launch)                 state_d = S_LOAD;
            S_LOAD: if (load_done)              state_d = S_WAIT;
            S_WAIT: if (rdy_hit || timed_out)   state_d = S_HOLD;
            S_HOLD: if (out_ready)              state_d = S_IDLE;
            default:                            state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        cnt_d       = cnt_q;
        sq_start_d  = sq_start_q;
        sq_x_d      = sq_x_q;
        out_valid_d = out_valid_q;
        out_y_d     = out_y_q;
        out_x_d     = out_x_q;
        out_err_d   = out_err_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (launch) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, launch})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (launch) begin
                    sq_x_d     = mem_q[rd_ptr_q];
                    sq_start_d = 1'b1;
                    cnt_d      = '0;
                end
            end
            S_LOAD: begin
                if (load_done) begin
                    sq_start_d = 1'b0;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (rdy_hit) begin
                    out_y_d     = sq_y;
                    out_x_d     = sq_x_q;
                    out_err_d   = 1'b0;
                    out_valid_d = 1'b1;
                end else if (timed_out) begin
                    out_y_d     = '0;
                    out_x_d     = sq_x_q;
                    out_err_d   = 1'b1;
                    out_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                sq_start_d = 1'b0;
            end
        endcase
    end

    assign sq_start  = sq_start_q;
    assign sq_x      = sq_x_q;
    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;
    assign out_x     = out_x_q;
    assign out_err   = out_err_q;
    assign level     = level_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_sqrt_dispatch.sv
// Bench for sqrt_dispatch: behavioural sqrt32 core model, operand scoreboard,
// table vectors, hand-written corner sequences and a randomized phase.
module tb_sqrt_dispatch;
  localparam int DEPTH        = 4;
  localparam int START_CYCLES = 2;
  localparam int TIMEOUT      = 64;
  localparam int LW           = $clog2(DEPTH) + 1;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic          sq_start;
  logic [31:0]   sq_x;
  logic          sq_rdy;
  logic [15:0]   sq_y;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_y;
  logic [31:0]   out_x;
  logic          out_err;
  logic [LW-1:0] level;
  logic [1:0]    dbg_state;

  typedef struct { logic [31:0] x; logic [15:0] y; logic err; } res_t;
  typedef struct { logic [31:0] x; logic [15:0] y; } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  res_t        got_q[$];

  // core model controls: 0 normal, 1 never ready, 2 rdy stuck high from before the launch
  int          core_mode = 0;
  int          core_lat  = 5;
  int          core_lat_q;
  int          core_cnt;
  logic        core_busy;
  logic [31:0] core_x;

  sqrt_dispatch #(
    .DEPTH(DEPTH),
    .START_CYCLES(START_CYCLES),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .sq_start(sq_start),
    .sq_x(sq_x),
    .sq_rdy(sq_rdy),
    .sq_y(sq_y),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_y(out_y),
    .out_x(out_x),
    .out_err(out_err),
    .level(level),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [15:0] isqrt(input logic [31:0] x);
    longint lo = 0;
    longint hi = 65536;
    longint xv = longint'({32'd0, x});
    while (hi - lo > 1) begin
      longint m = (lo + hi) / 2;
      if (m * m <= xv) lo = m;
      else hi = m;
    end
    return lo[15:0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // behavioural sqrt32: load while start is high, rdy rises core_lat cycles after start falls
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      sq_rdy     <= 1'b0;
      sq_y       <= '0;
      core_busy  <= 1'b0;
      core_cnt   <= 0;
      core_lat_q <= 0;
      core_x     <= '0;
    end else if (sq_start) begin
      core_busy  <= 1'b1;
      core_cnt   <= 0;
      core_x     <= sq_x;
      core_lat_q <= core_lat;
      if (core_mode == 2) begin
        sq_rdy <= 1'b1;
        sq_y   <= 16'hbeef;
      end else begin
        sq_rdy <= 1'b0;
      end
    end else if (core_busy && core_mode != 1) begin
      if (core_cnt >= core_lat_q) begin
        sq_rdy    <= 1'b1;
        sq_y      <= isqrt(core_x);
        core_busy <= 1'b0;
      end else begin
        if (core_cnt == 0) sq_rdy <= 1'b0;
        core_cnt <= core_cnt + 1;
      end
    end
  end

  // scoreboard: record accepted operands, compare each delivered result in order
  always @(negedge clk) begin
    if (reset) begin
      if (in_valid && in_ready) exp_q.push_back(in_data);
      chk("level_bound", 64'(level <= LW'(DEPTH)), 64'd1);
      if (level == LW'(DEPTH)) chk("ready_when_full", 64'(in_ready), 64'd0);
      if (out_valid && out_ready) begin
        res_t r;
        r.x = out_x;
        r.y = out_y;
        r.err = out_err;
        got_q.push_back(r);
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 64'(out_x), 64'hffff_ffff_ffff_ffff);
        end else begin
          logic [31:0] ex;
          logic        e_err;
          ex = exp_q.pop_front();
          e_err = (core_mode == 1);
          chk("sb_x", 64'(out_x), 64'(ex));
          chk("sb_err", 64'(out_err), 64'(e_err));
          chk("sb_y", 64'(out_y), e_err ? 64'd0 : 64'(isqrt(ex)));
        end
      end
    end
  end

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] x);
    int n = 0;
    in_valid = 1'b1;
    in_data  = x;
    @(negedge clk);
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("push_timeout", 64'd0, 64'd1);
    sync();
    in_valid = 1'b0;
  endtask

  task automatic wait_got(input int n, input string nm);
    int c = 0;
    while (got_q.size() < n && c < 3000) begin
      @(negedge clk);
      c++;
    end
    chk(nm, 64'(got_q.size() >= n), 64'd1);
  endtask

  task automatic wait_sig(input int which, input logic val, input string nm);
    int c = 0;
    @(negedge clk);
    while (((which == 0) ? sq_start : out_valid) !== val && c < 500) begin
      @(negedge clk);
      c++;
    end
    chk(nm, 64'(c < 500), 64'd1);
  endtask

  vec_t tbl[5];

  initial begin
    int base;
    int n;
    logic [15:0] y0;
    logic [31:0] x0;

    tbl[0] = '{32'd16, 16'd4};
    tbl[1] = '{32'd0, 16'd0};
    tbl[2] = '{32'd1000000, 16'd1000};
    tbl[3] = '{32'hffff_ffff, 16'd65535};
    tbl[4] = '{32'd2, 16'd1};

    reset = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;

    // reset state
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_sq_start", 64'(sq_start), 64'd0);
    chk("rst_sq_x", 64'(sq_x), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_y", 64'(out_y), 64'd0);
    chk("rst_out_x", 64'(out_x), 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    sync();
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);

    // table vectors back to back
    sync();
    out_ready = 1'b1;
    core_mode = 0;
    core_lat = 5;
    base = got_q.size();
    for (int i = 0; i < 5; i++) push(tbl[i].x);
    wait_got(base + 5, "tbl_count");
    for (int i = 0; i < 5; i++) begin
      if (got_q.size() > base + i) begin
        chk("tbl_x", 64'(got_q[base + i].x), 64'(tbl[i].x));
        chk("tbl_y", 64'(got_q[base + i].y), 64'(tbl[i].y));
        chk("tbl_err", 64'(got_q[base + i].err), 64'd0);
      end
    end

    // fill the FIFO while the core is busy and the output is stalled
    sync();
    out_ready = 1'b0;
    core_lat = 30;
    base = got_q.size();
    fork
      begin
        for (int i = 0; i < DEPTH + 2; i++) push(32'd100 + 32'(i) * 32'd7919);
      end
      begin
        int c = 0;
        @(negedge clk);
        while (level != LW'(DEPTH) && c < 200) begin
          @(negedge clk);
          c++;
        end
        chk("full_reached", 64'(level), 64'(DEPTH));
        chk("full_in_ready", 64'(in_ready), 64'd0);
        repeat (10) @(negedge clk);
        chk("full_still", 64'(level), 64'(DEPTH));
        chk("full_in_ready2", 64'(in_ready), 64'd0);
        sync();
        out_ready = 1'b1;
      end
    join
    wait_got(base + DEPTH + 2, "bp_count");

    // result held stable under backpressure, no relaunch before the handshake
    sync();
    out_ready = 1'b0;
    core_lat = 6;
    base = got_q.size();
    push(32'd144);
    push(32'd625);
    wait_sig(1, 1'b1, "hold_wait");
    y0 = out_y;
    x0 = out_x;
    chk("hold_first_y", 64'(y0), 64'd12);
    chk("hold_first_x", 64'(x0), 64'd144);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_y", 64'(out_y), 64'(y0));
      chk("hold_x", 64'(out_x), 64'(x0));
      chk("hold_no_start", 64'(sq_start), 64'd0);
    end
    sync();
    out_ready = 1'b1;
    wait_got(base + 2, "hold_count");

    // timeout: core never answers operand 81
    sync();
    core_mode = 1;
    base = got_q.size();
    push(32'd81);
    wait_sig(0, 1'b1, "to_start_hi");
    wait_sig(0, 1'b0, "to_start_lo");
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("to_cycles", 64'(n), 64'(TIMEOUT));
    wait_got(base + 1, "to_count");
    if (got_q.size() > base) begin
      chk("to_err", 64'(got_q[base].err), 64'd1);
      chk("to_y", 64'(got_q[base].y), 64'd0);
      chk("to_x", 64'(got_q[base].x), 64'd81);
    end
    sync();
    core_mode = 0;
    push(32'd9);
    wait_got(base + 2, "after_to_count");
    if (got_q.size() > base + 1) begin
      chk("after_to_y", 64'(got_q[base + 1].y), 64'd3);
      chk("after_to_err", 64'(got_q[base + 1].err), 64'd0);
    end

    // stale rdy held high through LOAD and the first WAIT cycle
    sync();
    core_mode = 2;
    core_lat = 8;
    base = got_q.size();
    push(32'd50);
    wait_got(base + 1, "stale_count");
    if (got_q.size() > base) chk("stale_y", 64'(got_q[base].y), 64'd7);
    sync();
    core_mode = 0;

    // asynchronous reset mid-WAIT with three operands queued
    core_lat = 40;
    out_ready = 1'b1;
    base = got_q.size();
    push(32'd1111);
    push(32'd2222);
    push(32'd3333);
    push(32'd4444);
    wait_sig(0, 1'b0, "rst_mid_wait");
    repeat (3) @(negedge clk);
    chk("rst_mid_level", 64'(level), 64'd3);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("arst_level", 64'(level), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd0);
    chk("arst_sq_start", 64'(sq_start), 64'd0);
    chk("arst_sq_x", 64'(sq_x), 64'd0);
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_out_y", 64'(out_y), 64'd0);
    chk("arst_out_x", 64'(out_x), 64'd0);
    chk("arst_out_err", 64'(out_err), 64'd0);
    exp_q.delete();
    repeat (2) sync();
    reset = 1'b1;
    core_lat = 4;
    push(32'd49);
    wait_got(base + 1, "arst_count");
    if (got_q.size() > base) begin
      chk("arst_x49", 64'(got_q[base].x), 64'd49);
      chk("arst_y49", 64'(got_q[base].y), 64'd7);
    end

    // randomized operands, latencies and output backpressure
    sync();
    base = got_q.size();
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          core_lat = $urandom_range(2, 20);
          push((i % 5 == 0) ? (32'hffff_ffff - 32'(i)) : $urandom());
          repeat ($urandom_range(0, 3)) sync();
        end
      end
      begin
        int c = 0;
        while (got_q.size() < base + 20 && c < 4000) begin
          sync();
          out_ready = 1'($urandom_range(0, 1));
          c++;
        end
      end
    join
    out_ready = 1'b1;
    wait_got(base + 20, "rand_count");
    repeat (5) @(negedge clk);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
